sumador_serie: RTL and testbench
================================

SUMADOR_SERIE -- requirements
Module: sumador_serie

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE or DONE.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each: the operands, captured on the accepting edge.
REQ-006 The block SHALL have port cin, input, 1 bit: carry-in, captured on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when a result completes.
REQ-009 The block SHALL have port sum, output, WIDTH bits: the last completed result.
REQ-010 The block SHALL have port cout, output, 1 bit: carry-out of the last completed result.

Function
REQ-011 The block SHALL add bit-serially, LSB first, one bit per clock, through a single full-adder instance plus a carry flip-flop.
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 The FSM SHALL move IDLE->RUN on start=1, RUN->DONE after exactly WIDTH RUN edges, DONE->RUN on start=1 and DONE->IDLE otherwise.
REQ-014 On the accepting edge the block SHALL load a and b into shift registers, load the carry flip-flop with cin and clear the bit counter.
REQ-015 On each RUN edge the block SHALL add the operand LSBs with the carry register, shift the sum bit into the working-register MSB, shift both operands right and store the carry-out in the carry register.
REQ-016 On the final RUN edge (counter = WIDTH-1) the block SHALL copy the completed working value to sum and the final carry to cout.
REQ-017 Latency: with start sampled at edge 0, busy SHALL be 1 in cycles 1..WIDTH, and done SHALL be 1 in cycle WIDTH+1 only.
REQ-018 sum and cout SHALL hold their previous result throughout RUN and change only on the final RUN edge.
REQ-019 start during RUN SHALL be ignored, with no effect on the operation in progress.
REQ-020 start in the DONE cycle SHALL be accepted, giving back-to-back operations with no IDLE cycle.
REQ-021 The result SHALL be arithmetic modulo 2^WIDTH, with cout equal to bit WIDTH of a+b+cin.

Reset
REQ-022 When rst=1 at a clock edge, the block SHALL force state IDLE, busy=0, done=0, sum=0, cout=0, carry register 0 and counter 0.
REQ-023 rst SHALL take priority over start.
REQ-024 When reset occurs mid-RUN, the block SHALL abandon the operation, SHALL NOT assert done, and SHALL update neither sum nor cout.

Configuration
REQ-025 When macro SUMADOR_SERIE_OVF_EN is defined, the block SHALL add output ovf, 1 bit, equal to (carry into MSB) XOR (carry out of MSB) for the last completed result.
REQ-026 With SUMADOR_SERIE_OVF_EN defined, ovf SHALL be updated on the final RUN edge, held thereafter, and reset to 0.
REQ-027 When SUMADOR_SERIE_OVF_EN is not defined, port ovf and its logic SHALL be absent.

Structure
REQ-028 Shared package sumador_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the constant SUMADOR_WIDTH_DEF = 8.
REQ-029 The per-bit addition SHALL be the existing full-adder module sumador_comp (port order a, b, cin, sum, cout), instantiated once as the only sub-module.

Verification
REQ-030 Bench (WIDTH=8): a=0x00, b=0x00, cin=0 -> done in cycle 9, sum=0x00, cout=0.
REQ-031 Bench (WIDTH=8): a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0x5A, b=0x3C, cin=1 -> sum=0x97, cout=0.
REQ-032 Bench (WIDTH=8): start pulsed again in cycle 4 of an operation -> ignored; a single done in cycle 9 with the first result.
REQ-033 Bench (WIDTH=8): start held high through DONE with new operands -> second busy begins in cycle 10 and second done occurs in cycle 18.
REQ-034 Bench (WIDTH=8): rst asserted in cycle 5 of RUN -> IDLE next cycle, no done, and sum/cout keep their prior values then clear to 0 (reset values).
REQ-035 Bench (WIDTH=8, with SUMADOR_SERIE_OVF_EN): a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.

Source files
------------

// File: rtl/sumador_pkg.sv
// Shared types and constants for the bit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sumador_pkg;

  localparam int SUMADOR_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sumador_state_t;

endpackage

// File: rtl/sumador_comp.sv
// One-bit full adder used as the single serial adder slice.
// Latency: combinational.
// Backpressure: none.
module sumador_comp (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/sumador_serie.sv
// Bit-serial adder: LSB-first, one bit per clock through one full adder; optional ovf via SUMADOR_SERIE_OVF_EN.
// Latency: start at edge 0 -> busy in cycles 1..WIDTH, done pulse in cycle WIDTH+1.
// Backpressure: start ignored while busy; start in the done cycle chains the next operation.
module sumador_serie
  import sumador_pkg::*;
#(
  parameter int WIDTH = SUMADOR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SUMADOR_SERIE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  sumador_state_t state, state_nxt;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  logic             last;

  // start is only honoured when no operation is in flight
  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last     = (cnt == CW'(WIDTH - 1));
  assign work_nxt = {fa_sum, work[WIDTH-1:1]};
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  sumador_comp u_fa (
    .a    (opa[0]),
    .b    (opb[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: run for exactly WIDTH edges, then a single done cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, shift one bit per RUN edge, publish result on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SUMADOR_SERIE_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      opa   <= a;
      opb   <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      opa   <= opa >> 1;
      opb   <= opb >> 1;
      work  <= work_nxt;
      carry <= fa_cout;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= work_nxt;
        cout <= fa_cout;
`ifdef SUMADOR_SERIE_OVF_EN
        // carry register still holds the carry into the MSB here
        ovf  <= carry ^ fa_cout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sumador_serie.sv
// Directed self-checking bench for sumador_serie at WIDTH=8.
// Latency: checks busy/done cycle-by-cycle relative to the start edge.
// Backpressure: covers start during RUN, chained start in DONE, reset mid-RUN.
module tb_sumador_serie;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SUMADOR_SERIE_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  // bench-side record of the last completed result
  logic [W-1:0] exp_sum;
  logic         exp_cout;

  always #5 clk = ~clk;

  sumador_serie #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SUMADOR_SERIE_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one full operation with cycle-exact busy/done and result-hold checks
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic [W-1:0] es, input logic ec, input string tag);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    step();                       // edge 0 -> cycle 1
    start = 1'b0;
    for (int c = 1; c <= W; c++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_nodone"}, {31'd0, done}, 32'd0);
      check({tag, "_sumhold"}, {24'd0, sum}, {24'd0, exp_sum});
      step();
    end
    // cycle W+1
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    check({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    exp_sum = es; exp_cout = ec;
    step();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    exp_sum = '0; exp_cout = 1'b0;
    step();
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
`ifdef SUMADOR_SERIE_OVF_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    // reset takes priority over start
    start = 1'b1;
    step();
    check("rst_prio_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; start = 1'b0;
    step();

    run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "wrap");
    run_op(8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, "mix");

    // start pulsed in cycle 4 is ignored
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    step();                       // cycle 1
    start = 1'b0;
    step(); step(); step();       // cycle 4
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    step();                       // cycle 5
    start = 1'b0;
    check("ign_busy5", {31'd0, busy}, 32'd1);
    for (int c = 5; c < W; c++) begin
      check("ign_nodone", {31'd0, done}, 32'd0);
      step();
    end
    check("ign_busy8", {31'd0, busy}, 32'd1);
    step();                       // cycle 9
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_sum", {24'd0, sum}, 32'h46);
    check("ign_cout", {31'd0, cout}, 32'd0);
    step();
    check("ign_single_done", {31'd0, done}, 32'd0);
    check("ign_idle", {31'd0, busy}, 32'd0);

    // start held through DONE: back-to-back operations
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    step();                       // cycle 1
    a = 8'hC8; b = 8'h64; cin = 1'b1;
    for (int c = 1; c < W; c++) step();
    check("b2b_busy8", {31'd0, busy}, 32'd1);
    step();                       // cycle 9
    check("b2b_done1", {31'd0, done}, 32'd1);
    check("b2b_sum1", {24'd0, sum}, 32'h30);
    check("b2b_cout1", {31'd0, cout}, 32'd0);
    step();                       // cycle 10
    check("b2b_busy10", {31'd0, busy}, 32'd1);
    check("b2b_done10", {31'd0, done}, 32'd0);
    for (int c = 10; c < 17; c++) step();
    check("b2b_busy17", {31'd0, busy}, 32'd1);
    check("b2b_hold17", {24'd0, sum}, 32'h30);
    start = 1'b0;
    step();                       // cycle 18
    check("b2b_done18", {31'd0, done}, 32'd1);
    check("b2b_sum2", {24'd0, sum}, 32'h2D);
    check("b2b_cout2", {31'd0, cout}, 32'd1);
    step();
    check("b2b_idle", {31'd0, busy}, 32'd0);
    check("b2b_done_pulse", {31'd0, done}, 32'd0);

    // reset in cycle 5 of RUN abandons the operation
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    step();                       // cycle 1
    start = 1'b0;
    step(); step(); step(); step(); // cycle 5
    check("mrst_busy5", {31'd0, busy}, 32'd1);
    check("mrst_sum_kept", {24'd0, sum}, 32'h2D);
    check("mrst_cout_kept", {31'd0, cout}, 32'd1);
    rst = 1'b1;
    step();                       // cycle 6
    rst = 1'b0;
    check("mrst_idle", {31'd0, busy}, 32'd0);
    check("mrst_nodone", {31'd0, done}, 32'd0);
    check("mrst_sum_clr", {24'd0, sum}, 32'd0);
    check("mrst_cout_clr", {31'd0, cout}, 32'd0);
    for (int c = 0; c < W + 2; c++) begin
      check("mrst_quiet", {30'd0, busy, done}, 32'd0);
      step();
    end
    exp_sum = '0; exp_cout = 1'b0;

`ifdef SUMADOR_SERIE_OVF_EN
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "ovf_pos");
    check("ovf_pos_flag", {31'd0, ovf}, 32'd1);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "ovf_neg");
    check("ovf_neg_flag", {31'd0, ovf}, 32'd1);
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "ovf_none");
    check("ovf_none_flag", {31'd0, ovf}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
